// File: rtl/bcp_run_ctrl.sv
// bcp_run_ctrl: run controller for one BCP solve pass.
//
// Streams a clause list into the distribution unit and then issues the
// decision literal. After that it watches the SAT datapath until one of
// three things happens: propagation goes quiet, a conflict is raised, or
// the cycle budget runs out. It then reports a registered result.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_start/cmd_uc      start request and decision literal (taken in IDLE only)
//   cmd_abort             return to IDLE from any state, clears result flags
//   cla_in_*              clause stream in (valid/ready, last marks final clause)
//   mem2carb_*            clause strobe/data, load finish, decision issue
//   carb_empty, ucq_empty, conflict   datapath status used in RUN
//   busy, done            activity and one-cycle completion pulse
//   res_*                 sticky conflict / timeout / overflow result flags
//   cla_count, run_cycles clauses accepted and RUN cycles of the current run
module bcp_run_ctrl #(
  parameter int NUM_ENGINE = 4,
  parameter int CLA_W      = 96,
  parameter int LIT_W      = 16,
  parameter int MAX_CLA    = 1024,
  parameter int QUIET_CYC  = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_start,
  input  logic [LIT_W-1:0]                  cmd_uc,
  input  logic                              cmd_abort,
  input  logic                              cla_in_valid,
  input  logic [CLA_W-1:0]                  cla_in,
  input  logic                              cla_in_last,
  output logic                              cla_in_ready,
  output logic                              mem2carb_start,
  output logic [CLA_W-1:0]                  mem2carb_clause,
  output logic                              mem2carb_finish,
  output logic                              mem2carb_uc_valid,
  output logic [LIT_W-1:0]                  mem2carb_uc,
  input  logic                              carb_empty,
  input  logic [NUM_ENGINE-1:0]             ucq_empty,
  input  logic                              conflict,
  output logic                              busy,
  output logic                              done,
  output logic                              res_conflict,
  output logic                              res_timeout,
  output logic                              res_overflow,
  output logic [$clog2(MAX_CLA+1)-1:0]      cla_count,
  output logic [$clog2(TIMEOUT+1)-1:0]      run_cycles
);

  localparam int CNT_W   = $clog2(MAX_CLA + 1);
  localparam int RUN_W   = $clog2(TIMEOUT + 1);
  localparam int QUIET_W = $clog2(QUIET_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_FINISH, S_ISSUE, S_RUN, S_DONE
  } state_e;

  state_e               state_q;
  logic [CLA_W-1:0]     clause_q;
  logic                 strobe_q;
  logic [LIT_W-1:0]     uc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [RUN_W-1:0]     run_q;
  logic [RUN_W-1:0]     run_d;
  logic [QUIET_W-1:0]   quiet_q;
  logic [QUIET_W-1:0]   quiet_d;
  logic                 conflict_q;
  logic                 timeout_q;
  logic                 overflow_q;
  logic                 quiet_cyc;

  // Both counters stop at their terminal value so they never wrap.
  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (v == RUN_W'(TIMEOUT)) ? v : v + 1'b1;
  endfunction

  function automatic logic [QUIET_W-1:0] sat_inc_quiet(input logic [QUIET_W-1:0] v);
    return (v == QUIET_W'(QUIET_CYC)) ? v : v + 1'b1;
  endfunction

  // A conflict cycle is never quiet, so a conflict also restarts the quiet count.
  assign quiet_cyc = carb_empty && (&ucq_empty) && !conflict;
  assign run_d     = sat_inc_run(run_q);
  assign quiet_d   = quiet_cyc ? sat_inc_quiet(quiet_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clause_q   <= '0;
      strobe_q   <= 1'b0;
      uc_q       <= '0;
      cnt_q      <= '0;
      run_q      <= '0;
      quiet_q    <= '0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (cmd_abort) begin
        // Abort beats everything, including a start in the same cycle.
        state_q    <= S_IDLE;
        conflict_q <= 1'b0;
        timeout_q  <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cmd_start) begin
              uc_q       <= cmd_uc;
              cnt_q      <= '0;
              run_q      <= '0;
              quiet_q    <= '0;
              conflict_q <= 1'b0;
              timeout_q  <= 1'b0;
              overflow_q <= 1'b0;
              state_q    <= S_LOAD;
            end
          end
          S_LOAD: begin
            // Ready is high for the whole of LOAD, so valid alone is a handshake.
            if (cla_in_valid) begin
              clause_q <= cla_in;
              strobe_q <= 1'b1;
              cnt_q    <= cnt_q + 1'b1;
              if (cla_in_last) begin
                state_q <= S_FLUSH;
              end else if (cnt_q == CNT_W'(MAX_CLA - 1)) begin
                overflow_q <= 1'b1;
                state_q    <= S_DONE;
              end
            end
          end
          S_FLUSH:  state_q <= S_FINISH;
          S_FINISH: state_q <= S_ISSUE;
          S_ISSUE: begin
            quiet_q <= '0;
            state_q <= S_RUN;
          end
          S_RUN: begin
            run_q   <= run_d;
            quiet_q <= quiet_d;
            if (conflict) begin
              conflict_q <= 1'b1;
              state_q    <= S_DONE;
            end else if (quiet_q == QUIET_W'(QUIET_CYC)) begin
              state_q <= S_DONE;
            end else if (run_q == RUN_W'(TIMEOUT)) begin
              timeout_q <= 1'b1;
              state_q   <= S_DONE;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cla_in_ready      = (state_q == S_LOAD);
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign mem2carb_finish   = (state_q == S_FINISH);
  assign mem2carb_uc_valid = (state_q == S_ISSUE);
  assign mem2carb_start    = strobe_q;
  assign mem2carb_clause   = clause_q;
  assign mem2carb_uc       = uc_q;
  assign res_conflict      = conflict_q;
  assign res_timeout       = timeout_q;
  assign res_overflow      = overflow_q;
  assign cla_count         = cnt_q;
  assign run_cycles        = run_q;

endmodule

// File: tb/tb_bcp_run_ctrl.sv
// Testbench for bcp_run_ctrl: cycle tables for the load/issue/run flow plus
// directed sequences for conflict, timeout, overflow, abort and reset.
module tb_bcp_run_ctrl;

  localparam int NE = 4;
  localparam int CW = 96;
  localparam int LW = 16;
  localparam int MC = 4;
  localparam int QC = 8;
  localparam int TO = 20;

  logic          clk;
  logic          rst_n;
  logic          cmd_start;
  logic [LW-1:0] cmd_uc;
  logic          cmd_abort;
  logic          cla_in_valid;
  logic [CW-1:0] cla_in;
  logic          cla_in_last;
  logic          cla_in_ready;
  logic          mem2carb_start;
  logic [CW-1:0] mem2carb_clause;
  logic          mem2carb_finish;
  logic          mem2carb_uc_valid;
  logic [LW-1:0] mem2carb_uc;
  logic          carb_empty;
  logic [NE-1:0] ucq_empty;
  logic          conflict;
  logic          busy;
  logic          done;
  logic          res_conflict;
  logic          res_timeout;
  logic          res_overflow;
  logic [2:0]    cla_count;
  logic [4:0]    run_cycles;

  int n_chk  = 0;
  int n_fail = 0;

  bcp_run_ctrl #(
    .NUM_ENGINE(NE), .CLA_W(CW), .LIT_W(LW),
    .MAX_CLA(MC), .QUIET_CYC(QC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_start(cmd_start), .cmd_uc(cmd_uc), .cmd_abort(cmd_abort),
    .cla_in_valid(cla_in_valid), .cla_in(cla_in), .cla_in_last(cla_in_last),
    .cla_in_ready(cla_in_ready),
    .mem2carb_start(mem2carb_start), .mem2carb_clause(mem2carb_clause),
    .mem2carb_finish(mem2carb_finish), .mem2carb_uc_valid(mem2carb_uc_valid),
    .mem2carb_uc(mem2carb_uc),
    .carb_empty(carb_empty), .ucq_empty(ucq_empty), .conflict(conflict),
    .busy(busy), .done(done),
    .res_conflict(res_conflict), .res_timeout(res_timeout), .res_overflow(res_overflow),
    .cla_count(cla_count), .run_cycles(run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [15:0] uc;
    logic        v;
    logic        l;
    logic [7:0]  d;
    logic        e_busy;
    logic        e_rdy;
    logic        e_stb;
    logic [7:0]  e_d;
    logic        e_fin;
    logic        e_ucv;
    logic [15:0] e_uc;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [15:0] uc, input logic v,
                              input logic l, input logic [7:0] d, input logic eb,
                              input logic er, input logic es, input logic [7:0] ed,
                              input logic ef, input logic eu, input logic [15:0] euc,
                              input logic edn);
    vec_t r;
    r.st = st; r.uc = uc; r.v = v; r.l = l; r.d = d;
    r.e_busy = eb; r.e_rdy = er; r.e_stb = es; r.e_d = ed;
    r.e_fin = ef; r.e_ucv = eu; r.e_uc = euc; r.e_done = edn;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_dp(input logic ce, input logic [3:0] ue, input logic cf);
    carb_empty = ce;
    ucq_empty  = ue;
    conflict   = cf;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      vec_t r;
      r = vecs[i];
      cmd_start    = r.st;
      cmd_uc       = r.uc;
      cla_in_valid = r.v;
      cla_in_last  = r.l;
      cla_in       = {12{r.d}};
      set_dp(1'b1, 4'hF, 1'b0);
      chk($sformatf("row%0d busy", i),   128'(busy),              128'(r.e_busy));
      chk($sformatf("row%0d ready", i),  128'(cla_in_ready),      128'(r.e_rdy));
      chk($sformatf("row%0d strobe", i), 128'(mem2carb_start),    128'(r.e_stb));
      chk($sformatf("row%0d finish", i), 128'(mem2carb_finish),   128'(r.e_fin));
      chk($sformatf("row%0d ucv", i),    128'(mem2carb_uc_valid), 128'(r.e_ucv));
      chk($sformatf("row%0d done", i),   128'(done),              128'(r.e_done));
      if (r.e_stb)
        chk($sformatf("row%0d clause", i), 128'(mem2carb_clause), 128'({12{r.e_d}}));
      if (r.e_ucv)
        chk($sformatf("row%0d uc", i), 128'(mem2carb_uc), 128'(r.e_uc));
      cyc();
    end
    cmd_start    = 1'b0;
    cla_in_valid = 1'b0;
    cla_in_last  = 1'b0;
  endtask

  // Start a run with n clauses; with a last marker it returns in the first RUN
  // cycle, without one it returns right after the n-th handshake.
  task automatic load_run(input logic [15:0] uc, input int n, input logic with_last);
    cmd_uc    = uc;
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cmd_uc    = 16'hDEAD;
    for (int i = 0; i < n; i++) begin
      cla_in_valid = 1'b1;
      cla_in_last  = with_last && (i == n - 1);
      cla_in       = {12{8'(i + 1)}};
      cyc();
    end
    cla_in_valid = 1'b0;
    cla_in_last  = 1'b0;
    if (with_last) repeat (3) cyc();
  endtask

  task automatic wait_done(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      cyc();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: no done within %0d cycles", bound);
    end
  endtask

  task automatic chk_flags(input string nm, input logic c, input logic t, input logic o);
    chk({nm, " res_conflict"}, 128'(res_conflict), 128'(c));
    chk({nm, " res_timeout"},  128'(res_timeout),  128'(t));
    chk({nm, " res_overflow"}, 128'(res_overflow), 128'(o));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    cmd_start = 1'b0; cmd_uc = '0; cmd_abort = 1'b0;
    cla_in_valid = 1'b0; cla_in = '0; cla_in_last = 1'b0;
    set_dp(1'b1, 4'hF, 1'b0);

    // Basic run: three back-to-back clauses, quiet datapath.
    vecs.push_back(mk(1, 16'h0005, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 1, 0, 8'h11, 1, 1, 0, 8'h00, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 1, 0, 8'h22, 1, 1, 1, 8'h11, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 1, 1, 8'h33, 1, 1, 1, 8'h22, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 1, 0, 1, 8'h33, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 16'h0005, 0));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 16'h0, 1));
    vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 16'h0, 0));
    // Valid gaps, including a last marker without valid that must be ignored.
    vecs.push_back(mk(1, 16'h00A5, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 1, 0, 8'h44, 1, 1, 0, 8'h00, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 0, 1, 8'hEE, 1, 1, 1, 8'h44, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 1, 0, 8'h55, 1, 1, 0, 8'h00, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 1, 1, 1, 8'h55, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 1, 1, 8'h66, 1, 1, 0, 8'h00, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 1, 0, 1, 8'h66, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 16'h00A5, 0));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 16'h0, 1));
    vecs.push_back(mk(0, 16'hBEEF, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 16'h0, 0));

    // Reset state
    cyc();
    cyc();
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset strobe", 128'(mem2carb_start), 128'(0));
    chk("reset count", 128'(cla_count), 128'(0));
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc();

    run_rows(0, 17);
    chk("basic cla_count", 128'(cla_count), 128'(3));
    chk("basic run_cycles", 128'(run_cycles), 128'(9));
    chk_flags("basic", 1'b0, 1'b0, 1'b0);

    run_rows(18, 37);
    chk("gap cla_count", 128'(cla_count), 128'(3));
    chk_flags("gap", 1'b0, 1'b0, 1'b0);

    // Conflict at RUN cycle 4 with quiet count 3.
    load_run(16'h0101, 2, 1'b1);
    set_dp(1'b0, 4'hF, 1'b0);
    cyc();
    set_dp(1'b1, 4'hF, 1'b0);
    repeat (3) cyc();
    chk("conf pre done", 128'(done), 128'(0));
    conflict = 1'b1;
    cyc();
    conflict = 1'b0;
    chk("conf done", 128'(done), 128'(1));
    chk("conf run_cycles", 128'(run_cycles), 128'(5));
    chk("conf cla_count", 128'(cla_count), 128'(2));
    chk_flags("conf", 1'b1, 1'b0, 1'b0);
    cyc();
    chk("conf idle busy", 128'(busy), 128'(0));
    chk("conf sticky", 128'(res_conflict), 128'(1));

    // Timeout with engine 1 never draining.
    load_run(16'h0202, 1, 1'b1);
    set_dp(1'b1, 4'b1101, 1'b0);
    wait_done(40, n);
    chk("tmo latency", 128'(n), 128'(21));
    chk("tmo run_cycles", 128'(run_cycles), 128'(20));
    chk_flags("tmo", 1'b0, 1'b1, 1'b0);
    cyc();

    // Conflict on the timeout cycle wins.
    load_run(16'h0303, 1, 1'b1);
    set_dp(1'b1, 4'b1101, 1'b0);
    repeat (20) cyc();
    chk("tmoconf pre done", 128'(done), 128'(0));
    conflict = 1'b1;
    cyc();
    conflict = 1'b0;
    chk("tmoconf done", 128'(done), 128'(1));
    chk_flags("tmoconf", 1'b1, 1'b0, 1'b0);
    cyc();

    // Quiet completion on the timeout cycle wins over timeout.
    load_run(16'h0404, 1, 1'b1);
    set_dp(1'b1, 4'b1101, 1'b0);
    repeat (12) cyc();
    set_dp(1'b1, 4'hF, 1'b0);
    wait_done(20, n);
    chk("quiettmo latency", 128'(n), 128'(9));
    chk("quiettmo run_cycles", 128'(run_cycles), 128'(20));
    chk_flags("quiettmo", 1'b0, 1'b0, 1'b0);
    cyc();

    // Overflow: four clauses, no last.
    cmd_uc = 16'h0505;
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cla_in_valid = 1'b1;
      cla_in = {12{8'(i + 16)}};
      chk("ovf ready", 128'(cla_in_ready), 128'(1));
      chk("ovf no finish/ucv", 128'(mem2carb_finish | mem2carb_uc_valid), 128'(0));
      cyc();
    end
    cla_in_valid = 1'b0;
    chk("ovf done", 128'(done), 128'(1));
    chk("ovf cla_count", 128'(cla_count), 128'(4));
    chk("ovf strobe", 128'(mem2carb_start), 128'(1));
    chk("ovf clause", 128'(mem2carb_clause), 128'({12{8'h13}}));
    chk("ovf no finish/ucv", 128'(mem2carb_finish | mem2carb_uc_valid), 128'(0));
    chk_flags("ovf", 1'b0, 1'b0, 1'b1);
    cyc();
    chk("ovf idle busy", 128'(busy), 128'(0));
    chk("ovf idle no finish/ucv", 128'(mem2carb_finish | mem2carb_uc_valid), 128'(0));

    // Abort beats a same-cycle start in IDLE and clears the flags.
    cmd_start = 1'b1;
    cmd_abort = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    chk("abortstart busy", 128'(busy), 128'(0));
    chk_flags("abortstart", 1'b0, 1'b0, 1'b0);

    // Start during RUN is ignored; abort in RUN ends the run without done.
    load_run(16'h0033, 1, 1'b1);
    set_dp(1'b0, 4'hF, 1'b0);
    repeat (2) cyc();
    cmd_start = 1'b1;
    cmd_uc = 16'h0077;
    cyc();
    cmd_start = 1'b0;
    chk("ignstart busy", 128'(busy), 128'(1));
    chk("ignstart ready", 128'(cla_in_ready), 128'(0));
    chk("ignstart uc", 128'(mem2carb_uc), 128'(16'h0033));
    cmd_abort = 1'b1;
    cyc();
    cmd_abort = 1'b0;
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort done", 128'(done), 128'(0));
    chk_flags("abort", 1'b0, 1'b0, 1'b0);
    cyc();
    chk("abort later done", 128'(done), 128'(0));
    set_dp(1'b1, 4'hF, 1'b0);

    // Asynchronous reset in LOAD.
    cmd_uc = 16'h4444;
    cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cla_in_valid = 1'b1;
    cla_in = {12{8'h99}};
    cyc();
    cla_in_valid = 1'b0;
    chk("prereset strobe", 128'(mem2carb_start), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("areset busy", 128'(busy), 128'(0));
    chk("areset ready", 128'(cla_in_ready), 128'(0));
    chk("areset strobe", 128'(mem2carb_start), 128'(0));
    chk("areset clause", 128'(mem2carb_clause), 128'(0));
    chk("areset uc", 128'(mem2carb_uc), 128'(0));
    chk("areset cla_count", 128'(cla_count), 128'(0));
    chk("areset run_cycles", 128'(run_cycles), 128'(0));
    chk("areset done", 128'(done), 128'(0));
    chk_flags("areset", 1'b0, 1'b0, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
